// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame receiver and the register bank it feeds:
// default field widths, receiver FSM states and register-bank addresses.
package spi_pkg;

    // Default frame layout: {read_write, addr, data}, MSB first on the wire.
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,  // after reset: wait until chip select is seen high
        IDLE      = 2'd1,  // bus idle, waiting for chip select to fall
        SHIFT     = 2'd2   // frame in progress
    } spi_state_e;

    // Register-bank address map shared with the downstream register bank.
    localparam logic [ADDR_W-1:0] REG_ID     = 7'h00;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 7'h01;
    localparam logic [ADDR_W-1:0] REG_CFG    = 7'h02;
    localparam logic [ADDR_W-1:0] REG_THRESH = 7'h03;
    localparam logic [ADDR_W-1:0] REG_IRQ    = 7'h04;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus rise/fall detection
// on the synchronized level. All flops reset to 0.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep one extra copy of
    // the synchronized level for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse
    // the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_frame_rx.sv
// SPI target-side frame receiver (mode 0, MSB first). Synchronizes sclk, copi
// and ncs into clk, collects one FRAME_W-bit frame per chip-select assertion
// and hands well-formed frames to the register bank as a one-cycle valid
// pulse. Frames with any other bit count are dropped with a frame_err pulse.
// Optional build macro SPI_ERR_COUNT_EN adds a saturating 8-bit err_count.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = spi_pkg::ADDR_W,
    parameter int DATA_W      = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              valid,
    output logic              read_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              frame_err
`ifdef SPI_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    import spi_pkg::spi_state_e;
    import spi_pkg::WAIT_IDLE;
    import spi_pkg::IDLE;
    import spi_pkg::SHIFT;

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    // Counter must hold FRAME_W+1 so an overlong frame never reads as FRAME_W.
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    // ---------------------------------------------------------------------
    // Pin synchronization and edge detection
    // ---------------------------------------------------------------------
    logic sclk_s;
    logic sclk_rise;
    logic sclk_fall_unused;
    logic ncs_s;
    logic ncs_rise;
    logic ncs_fall;
    logic copi_s;
    logic [SYNC_STAGES-1:0] copi_sync_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sclk),
        .level (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    // The ncs chain resets to 0, so the FSM must see a genuine high level
    // before it will accept a falling edge as a frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ncs),
        .level (ncs_s),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    // copi runs through a chain of the same depth as sclk so the bit presented
    // at the end of the chain lines up with the detected sclk rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_sync_q <= '0;
        end else begin
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    spi_state_e       state_q;
    spi_state_e       state_d;
    logic             frame_clear;
    logic             shift_en;
    logic             frame_ok;
    logic             frame_bad;
    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   count_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. ncs edges take priority over sclk, so a
    // clock edge coinciding with either chip-select edge is never counted.
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        frame_clear = 1'b0;
        shift_en    = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (ncs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ncs_fall) begin
                    frame_clear = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (count_q == CNT_FULL) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end else if (sclk_rise && !ncs_s) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (frame_clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[FRAME_W-2:0], copi_s};
            if (count_q != CNT_SAT) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Result pulses, one clk after the ncs rising edge is detected, and the
    // frame fields, which change only together with a valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            read_write <= 1'b0;
            addr       <= '0;
            data       <= '0;
        end else begin
            valid     <= frame_ok;
            frame_err <= frame_bad;
            if (frame_ok) begin
                read_write <= shift_q[FRAME_W-1];
                addr       <= shift_q[FRAME_W-2 -: ADDR_W];
                data       <= shift_q[DATA_W-1:0];
            end
        end
    end

`ifdef SPI_ERR_COUNT_EN
    // Count dropped frames, sticking at 0xFF instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (frame_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule : spi_frame_rx

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx. Stimulus tasks push the expected
// outcome of each frame into a scoreboard queue; a monitor pops one entry per
// valid/frame_err pulse and compares. Build with SPI_ERR_COUNT_EN defined to
// also exercise the saturating error counter.
module tb_spi_frame_rx;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef struct {
        logic              is_err;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sclk;
    logic              copi;
    logic              ncs;
    logic              valid;
    logic              read_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              frame_err;
`ifdef SPI_ERR_COUNT_EN
    logic [7:0]        err_count;
`endif

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_valid = 0;
    int   n_err   = 0;

    always #5 clk = ~clk;

    spi_frame_rx #(
        .SYNC_STAGES (2),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .copi       (copi),
        .ncs        (ncs),
        .valid      (valid),
        .read_write (read_write),
        .addr       (addr),
        .data       (data),
        .frame_err  (frame_err)
`ifdef SPI_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (valid === 1'b1 || frame_err === 1'b1)) begin
            if (valid === 1'b1) n_valid++;
            if (frame_err === 1'b1) n_err++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b, wanted no pulse",
                         valid, frame_err);
            end else begin
                e = sb_q.pop_front();
                if (e.is_err) begin
                    if (frame_err !== 1'b1 || valid !== 1'b0) begin
                        bad++;
                        $display("FAIL err_pulse: got valid=%0b frame_err=%0b, wanted valid=0 frame_err=1",
                                 valid, frame_err);
                    end
                end else if (valid !== 1'b1 || frame_err !== 1'b0 || read_write !== e.rw ||
                             addr !== e.addr || data !== e.data) begin
                    bad++;
                    $display("FAIL frame_fields: got v=%0b e=%0b rw=%0b addr=%02h data=%02h, wanted v=1 e=0 rw=%0b addr=%02h data=%02h",
                             valid, frame_err, read_write, addr, data, e.rw, e.addr, e.data);
                end
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (pins change on the falling clk edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ok(input logic [15:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.rw     = v[15];
        e.addr   = v[14:8];
        e.data   = v[7:0];
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.rw     = 1'b0;
        e.addr   = '0;
        e.data   = '0;
        sb_q.push_back(e);
    endtask

    task automatic start_frame();
        ncs = 1'b0;
        idle(4);
    endtask

    // Clock n bits, MSB of v first; bits past 16 are sent as 0.
    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            copi = (i < 16) ? v[15 - i] : 1'b0;
            idle(4);
            sclk = 1'b1;
            idle(4);
            sclk = 1'b0;
        end
    endtask

    // Raise ncs and report on which falling edge a result pulse first appears.
    task automatic end_frame(output int lat);
        idle(4);
        ncs = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat == 0 && (valid === 1'b1 || frame_err === 1'b1)) lat = i;
        end
    endtask

    task automatic send_frame(input logic [15:0] v, input int n);
        int lat;
        start_frame();
        shift_bits(v, n);
        end_frame(lat);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: %0d expected pulses never arrived, wanted 0 pending",
                     name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_held(input string name, input logic rw_e,
                              input logic [ADDR_W-1:0] addr_e, input logic [DATA_W-1:0] data_e);
        total++;
        if (read_write !== rw_e || addr !== addr_e || data !== data_e) begin
            bad++;
            $display("FAIL %s: got rw=%0b addr=%02h data=%02h, wanted rw=%0b addr=%02h data=%02h",
                     name, read_write, addr, data, rw_e, addr_e, data_e);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        idle(3);
        total++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: got valid=%0b frame_err=%0b, wanted 0 0", valid, frame_err);
        end
        check_held("reset_fields", 1'b0, 7'h00, 8'h00);
`ifdef SPI_ERR_COUNT_EN
        total++;
        if (err_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_err_count: got %02h, wanted 00", err_count);
        end
`endif
        rst_n = 1'b1;
        idle(6);
    endtask

    task automatic test_write();
        int lat;
        push_ok(16'h8480);
        start_frame();
        shift_bits(16'h8480, 16);
        end_frame(lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL write_latency: got pulse on falling edge %0d after ncs high, wanted 3", lat);
        end
        wait_drain("write");
        idle(4);
        check_held("write_held", 1'b1, 7'h04, 8'h80);
    endtask

    task automatic test_read();
        push_ok(16'h0155);
        send_frame(16'h0155, 16);
        wait_drain("read");
        check_held("read_held", 1'b0, 7'h01, 8'h55);
    endtask

    task automatic test_short_long();
        int nv;
        nv = n_valid;
        push_err();
        send_frame(16'hABCD, 15);
        push_err();
        send_frame(16'h8480, 17);
        wait_drain("short_long");
        check_held("short_long_held", 1'b0, 7'h01, 8'h55);
        total++;
        if (n_valid != nv) begin
            bad++;
            $display("FAIL short_long_no_valid: got %0d valid pulses, wanted 0", n_valid - nv);
        end
    endtask

    task automatic test_zero_bits();
        int lat;
        push_err();
        start_frame();
        end_frame(lat);
        wait_drain("zero_bits");
        check_held("zero_bits_held", 1'b0, 7'h01, 8'h55);
        push_ok(16'h82A5);
        send_frame(16'h82A5, 16);
        wait_drain("after_zero");
        check_held("after_zero_held", 1'b1, 7'h02, 8'hA5);
    endtask

    task automatic test_mid_reset();
        int nv;
        int ne;
        int lat;
        nv = n_valid;
        ne = n_err;
        start_frame();
        shift_bits(16'hFFFF, 8);
        rst_n = 1'b0;
        idle(2);
        check_held("mid_reset_cleared", 1'b0, 7'h00, 8'h00);
        rst_n = 1'b1;
        idle(2);
        shift_bits(16'hA5FF, 8);
        end_frame(lat);
        idle(10);
        total++;
        if (n_valid != nv || n_err != ne) begin
            bad++;
            $display("FAIL mid_reset_no_pulse: got %0d valid and %0d err pulses, wanted 0 and 0",
                     n_valid - nv, n_err - ne);
        end
        push_ok(16'h83FF);
        send_frame(16'h83FF, 16);
        wait_drain("after_reset");
        check_held("after_reset_held", 1'b1, 7'h03, 8'hFF);
    endtask

    // Chip select is high for a single clk, so frame A's valid pulse lands on
    // the same cycle as frame B's ncs falling edge.
    task automatic test_back_to_back();
        int lat;
        push_ok(16'h8155);
        push_ok(16'h04C3);
        start_frame();
        shift_bits(16'h8155, 16);
        idle(4);
        ncs = 1'b1;
        idle(1);
        ncs = 1'b0;
        idle(4);
        shift_bits(16'h04C3, 16);
        end_frame(lat);
        wait_drain("back_to_back");
        check_held("back_to_back_held", 1'b0, 7'h04, 8'hC3);
    endtask

`ifdef SPI_ERR_COUNT_EN
    task automatic test_err_count();
        for (int i = 0; i < 300; i++) begin
            push_err();
            ncs = 1'b0;
            idle(4);
            ncs = 1'b1;
            idle(8);
        end
        wait_drain("err_count");
        idle(2);
        total++;
        if (err_count !== 8'hFF) begin
            bad++;
            $display("FAIL err_count_sat: got %02h, wanted ff", err_count);
        end
        push_err();
        ncs = 1'b0;
        idle(4);
        ncs = 1'b1;
        idle(8);
        wait_drain("err_count_hold");
        idle(2);
        total++;
        if (err_count !== 8'hFF) begin
            bad++;
            $display("FAIL err_count_hold: got %02h, wanted ff", err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_short_long();
        test_zero_bits();
        test_mid_reset();
        test_back_to_back();
`ifdef SPI_ERR_COUNT_EN
        test_err_count();
`endif
        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_frame_rx
